// File: rtl/uart_byte_tx.sv
// uart_byte_tx
// Serial UART transmitter. Each accepted start request carries one byte that is
// sent LSB-first as: start bit (0), 8 data bits, optional parity bit, and
// STOP_BITS stop bits (1). Each bit is held for CLKS_PER_BIT clocks. A single
// done pulse marks the final clock of the last stop bit. A new byte may be
// accepted in that same cycle, so frames can run back-to-back with no idle gap.
//
// Ports:
//   clock    system clock
//   reset    asynchronous, active-high reset
//   start    transmit request, honoured only while ready (IDLE or done cycle)
//   data_in  byte to send, captured in the cycle start is accepted
//   bit_o    serial line, idles high
//   busy     high while a frame is in progress, including the done cycle
//   done     one-cycle pulse in the last clock of the last stop bit
`timescale 1ns/1ps

module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       bit_o,
    output logic       busy,
    output logic       done
);

    localparam int            CW            = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic          STOP_LAST     = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          stop_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          accept;

    // Odd parity makes the total count of ones odd, even parity makes it even.
    function automatic logic parity_of(input logic [7:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // done is itself a register, so ready depends only on state and flops;
    // start never reaches done combinationally.
    assign accept = start && ((state == IDLE) || done);

    // NOTE: every state register uses non-blocking assignment so all flops
    // update together from the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            // NOTE: the shift register is a plain 8-bit register (not memory),
            // so clearing it on reset costs nothing and keeps it deterministic.
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_o      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (accept) begin
            // Capture must happen now: upstream moves on to the next byte.
            shift_reg  <= data_in;
            parity_bit <= parity_of(data_in);
            state      <= START_BIT;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            bit_o      <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_o <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                START_BIT: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        bit_o    <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
                            if (PARITY != 0) begin
                                state <= PARITY_BIT;
                                bit_o <= parity_bit;
                            end else begin
                                state <= STOP;
                                bit_o <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            bit_o   <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY_BIT: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                        bit_o    <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (done) begin
                        // Frame complete and no follow-on byte was offered.
                        done     <= 1'b0;
                        baud_cnt <= '0;
                        stop_cnt <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bit_o    <= 1'b1;
                    end else if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        stop_cnt <= stop_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // Raise done one edge early so it is registered and
                        // coincides with the final clock of the last stop bit.
                        done     <= (baud_cnt == BAUD_PRE_LAST) && (stop_cnt == STOP_LAST);
                    end
                end

                default: begin
                    state <= IDLE;
                    bit_o <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
